// File: rtl/octal_display_pkg.sv
// Shared constants and digit helper for the octal display scan path.
// Values are packed octal: digit i occupies bits [3i+2:3i].
package octal_display_pkg;

  localparam int DIGIT_W          = 3;
  localparam int MAX_DIGITS       = 8;
  localparam int DEFAULT_PRESCALE = 50000;

  // Callers zero-extend their value to the widest supported digit count.
  function automatic logic [DIGIT_W-1:0] get_digit(
    input logic [MAX_DIGITS*DIGIT_W-1:0] packed_value,
    input int                            i
  );
    return packed_value[i*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running modulo-PRESCALE counter; adv is high in the cycle the count wraps.
// Reusable for refresh and debounce timing.
module scan_prescaler
  import octal_display_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  output logic adv
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_q;

  // With PRESCALE=1 the count is pinned at 0 and adv is permanently high.
  assign adv = (pre_q == LAST);

  always_ff @(posedge clk) begin
    if (rst)
      pre_q <= '0;
    else if (adv)
      pre_q <= '0;
    else
      pre_q <= pre_q + 1'b1;
  end

endmodule

// File: rtl/octal_display_scanner.sv
// Time-multiplexed octal digit scanner driving the seven-segment decoder.
// Optional leading-zero blanking: define OCTAL_DISPLAY_BLANK_EN.
module octal_display_scanner
  import octal_display_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [DIGIT_W*NDIGITS-1:0] value,
  output logic [DIGIT_W-1:0]         digit,
  output logic [NDIGITS-1:0]         an_n,
  output logic                       frame
);

  localparam int IW = $clog2(NDIGITS);
  localparam int VW = DIGIT_W * NDIGITS;
  localparam logic [IW-1:0]      LAST_IDX = IW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] AN_RESET = ~NDIGITS'(1);

  logic                           adv;
  logic [VW-1:0]                  value_q, value_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [MAX_DIGITS*DIGIT_W-1:0]  value_ext;
  logic [DIGIT_W-1:0]             digit_d;
  logic [NDIGITS-1:0]             an_d;
  logic                           wrap;

  scan_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk(clk),
    .rst(rst),
    .adv(adv)
  );

  // Outputs are built from next-state index and value so they switch on the same edge as idx_q.
  always_comb begin
    value_d   = load ? value : value_q;
    idx_d     = idx_q;
    wrap      = 1'b0;
    if (adv) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    value_ext = (MAX_DIGITS*DIGIT_W)'(value_d);
    digit_d   = get_digit(value_ext, int'(idx_d));
    an_d      = ~(NDIGITS'(1) << idx_d);
`ifdef OCTAL_DISPLAY_BLANK_EN
    // A slot above 0 goes dark when it and every more significant digit are zero.
    if ((idx_d != '0) && ((value_d >> (DIGIT_W * int'(idx_d))) == '0)) begin
      digit_d = '0;
      an_d    = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      idx_q   <= '0;
      digit   <= '0;
      an_n    <= AN_RESET;
      frame   <= 1'b0;
    end else begin
      value_q <= value_d;
      idx_q   <= idx_d;
      digit   <= digit_d;
      an_n    <= an_d;
      frame   <= wrap;
    end
  end

endmodule

// File: tb/tb_octal_display_scanner.sv
// Directed self-checking bench for octal_display_scanner (NDIGITS=4, PRESCALE=4 and PRESCALE=1).
module tb_octal_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [11:0] value = '0;
  logic [2:0]  digit;
  logic [3:0]  an_n;
  logic        frame;

  logic        load1 = 1'b0;
  logic [11:0] value1 = '0;
  logic [2:0]  digit1;
  logic [3:0]  an_n1;
  logic        frame1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  octal_display_scanner #(.NDIGITS(4), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .digit(digit), .an_n(an_n), .frame(frame)
  );

  octal_display_scanner #(.NDIGITS(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .value(value1),
    .digit(digit1), .an_n(an_n1), .frame(frame1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst low; the next posedge is edge 1 of the scan.
  task automatic do_reset();
    rst = 1'b1; load = 1'b0; load1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (digit !== 3'd0 || an_n !== 4'b1110 || frame !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got digit=%0d an_n=%b frame=%b, want 0 1110 0", digit, an_n, frame);
    end
    rst = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (an_n !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL reset_slot0_hold: got an_n=%b want 1110", an_n);
    end
    tick();
    vectors++;
    if (an_n !== 4'b1101) begin
      miscompares++;
      $display("[TB] FAIL reset_first_step: got an_n=%b want 1101", an_n);
    end
  endtask

  task automatic test_scan_order();
    logic [2:0] exp_digits [4] = '{3'd1, 3'd5, 3'd3, 3'd7};
    logic [3:0] exp_an     [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int idx;
    do_reset();
    load = 1'b1; value = 12'o7351;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = (k / 4) % 4;
      vectors++;
      if (digit !== exp_digits[idx] || an_n !== exp_an[idx]) begin
        miscompares++;
        $display("[TB] FAIL scan_edge%0d: got digit=%0d an_n=%b want %0d %b", k, digit, an_n, exp_digits[idx], exp_an[idx]);
      end
      vectors++;
      if (frame !== (k == 16)) begin
        miscompares++;
        $display("[TB] FAIL scan_frame_edge%0d: got %b want %b", k, frame, (k == 16));
      end
      if (k < 16) tick();
    end
  endtask

  task automatic test_load_mid_slot();
    do_reset();
    load = 1'b1; value = 12'o0001;
    tick();
    load = 1'b0;
    repeat (8) tick();
    vectors++;
    if (digit !== 3'd0 || an_n !== 4'b1011) begin
      miscompares++;
      $display("[TB] FAIL mid_before_load: got digit=%0d an_n=%b want 0 1011", digit, an_n);
    end
    load = 1'b1; value = 12'o0421;
    tick();
    load = 1'b0;
    vectors++;
    if (digit !== 3'd4 || an_n !== 4'b1011) begin
      miscompares++;
      $display("[TB] FAIL mid_after_load: got digit=%0d an_n=%b want 4 1011", digit, an_n);
    end
    tick();
    vectors++;
    if (digit !== 3'd4 || an_n !== 4'b1011) begin
      miscompares++;
      $display("[TB] FAIL mid_slot_hold: got digit=%0d an_n=%b want 4 1011", digit, an_n);
    end
    tick();
    vectors++;
    if (digit !== 3'd0 || an_n !== 4'b0111) begin
      miscompares++;
      $display("[TB] FAIL mid_slot_boundary: got digit=%0d an_n=%b want 0 0111", digit, an_n);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    load = 1'b1; value = 12'o7777;
    tick();
    load = 1'b0;
    repeat (12) tick();
    vectors++;
    if (digit !== 3'd7 || an_n !== 4'b0111) begin
      miscompares++;
      $display("[TB] FAIL rmid_slot3: got digit=%0d an_n=%b want 7 0111", digit, an_n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (digit !== 3'd0 || an_n !== 4'b1110 || frame !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rmid_reset: got digit=%0d an_n=%b frame=%b want 0 1110 0", digit, an_n, frame);
    end
    repeat (3) tick();
    vectors++;
    if (an_n !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL rmid_restart_hold: got an_n=%b want 1110", an_n);
    end
    tick();
    vectors++;
    if (an_n !== 4'b1101 || digit !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL rmid_restart_step: got digit=%0d an_n=%b want 0 1101", digit, an_n);
    end
  endtask

  task automatic test_prescale_one();
    logic [2:0] exp_digits [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    do_reset();
    load1 = 1'b1; value1 = 12'o0123;
    tick();
    load1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      vectors++;
      if (digit1 !== exp_digits[k % 4] || frame1 !== (k % 4 == 0)) begin
        miscompares++;
        $display("[TB] FAIL p1_edge%0d: got digit=%0d frame=%b want %0d %b", k, digit1, frame1, exp_digits[k % 4], (k % 4 == 0));
      end
      if (k < 8) tick();
    end
  endtask

`ifdef OCTAL_DISPLAY_BLANK_EN
  task automatic test_blanking();
    logic [2:0] exp_d30 [4] = '{3'd0, 3'd3, 3'd0, 3'd0};
    logic [3:0] exp_a30 [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [3:0] exp_a0  [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    int idx;
    do_reset();
    load = 1'b1; value = 12'o0030;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = (k / 4) % 4;
      vectors++;
      if (digit !== exp_d30[idx] || an_n !== exp_a30[idx]) begin
        miscompares++;
        $display("[TB] FAIL blank30_edge%0d: got digit=%0d an_n=%b want %0d %b", k, digit, an_n, exp_d30[idx], exp_a30[idx]);
      end
      if (k == 16) begin
        load = 1'b1; value = 12'o0000;
      end
      tick();
      load = 1'b0;
    end
    for (int k = 17; k <= 32; k++) begin
      idx = (k / 4) % 4;
      vectors++;
      if (digit !== 3'd0 || an_n !== exp_a0[idx]) begin
        miscompares++;
        $display("[TB] FAIL blank0_edge%0d: got digit=%0d an_n=%b want 0 %b", k, digit, an_n, exp_a0[idx]);
      end
      if (k < 32) tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_order();
    test_load_mid_slot();
    test_reset_mid_scan();
    test_prescale_one();
`ifdef OCTAL_DISPLAY_BLANK_EN
    test_blanking();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
